// File: rtl/pe_load_sequencer.sv
// PE load/compute initiator: streams one kernel and one activation tile from the GLB into a PE, then collects NUM_OUT psums.
// Optional macro PSUM_RELU_EN clamps negative psums to zero before they are written.
module pe_load_sequencer #(
    parameter int DATA_BITWIDTH = 16,
    parameter int ADDR_BITWIDTH = 10,
    parameter int KERNEL_SIZE   = 3,
    parameter int ACT_SIZE      = 5,
    parameter int W_BASE        = 0,
    parameter int A_BASE        = 64,
    parameter int PSUM_BASE     = 0
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     go,
    output logic                     busy,
    output logic                     done,
    output logic                     glb_rd_en,
    output logic [ADDR_BITWIDTH-1:0] glb_rd_addr,
    input  logic [DATA_BITWIDTH-1:0] glb_rd_data,
    output logic                     pe_load_en_wght,
    output logic                     pe_load_en_act,
    output logic [DATA_BITWIDTH-1:0] pe_filt,
    output logic [DATA_BITWIDTH-1:0] pe_act,
    input  logic                     pe_load_done,
    output logic                     pe_start,
    input  logic                     pe_compute_done,
    input  logic [DATA_BITWIDTH-1:0] pe_out,
    output logic                     ps_wr_en,
    output logic [ADDR_BITWIDTH-1:0] ps_wr_addr,
    output logic [DATA_BITWIDTH-1:0] ps_wr_data
);

    localparam int W_CNT   = KERNEL_SIZE * KERNEL_SIZE;
    localparam int A_CNT   = ACT_SIZE * ACT_SIZE;
    localparam int NUM_OUT = ACT_SIZE - KERNEL_SIZE + 1;
    localparam int MAX_CNT = (A_CNT > W_CNT) ? A_CNT : W_CNT;
    localparam int CNT_W   = $clog2(MAX_CNT + 1);
    localparam int OCNT_W  = $clog2(NUM_OUT + 1);

    typedef enum logic [3:0] {
        IDLE,
        LW_FETCH,
        LW_WAIT,
        LA_FETCH,
        LA_WAIT,
        START,
        WAIT_CD,
        CAPTURE,
        GAP,
        DONE
    } state_t;

    state_t              state, state_nx;
    logic [CNT_W-1:0]    cnt, cnt_nx;
    logic [OCNT_W-1:0]   out_cnt, out_cnt_nx;
    logic                cd_prev;
    logic                rd_v, rd_act, rd_first;
    logic [DATA_BITWIDTH-1:0] psum_val;

`ifdef PSUM_RELU_EN
    assign psum_val = pe_out[DATA_BITWIDTH-1] ? '0 : pe_out;
`else
    assign psum_val = pe_out;
`endif

    // GLB data lands one cycle after the read; tag it with phase and first-element so the stream register can route it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state           <= IDLE;
            cnt             <= '0;
            out_cnt         <= '0;
            cd_prev         <= 1'b0;
            rd_v            <= 1'b0;
            rd_act          <= 1'b0;
            rd_first        <= 1'b0;
            pe_filt         <= '0;
            pe_act          <= '0;
            pe_load_en_wght <= 1'b0;
            pe_load_en_act  <= 1'b0;
        end else begin
            state           <= state_nx;
            cnt             <= cnt_nx;
            out_cnt         <= out_cnt_nx;
            cd_prev         <= pe_compute_done;
            rd_v            <= glb_rd_en;
            rd_act          <= (state == LA_FETCH);
            rd_first        <= (cnt == '0);
            pe_load_en_wght <= rd_v && !rd_act && rd_first;
            pe_load_en_act  <= rd_v && rd_act && rd_first;
            if (rd_v && !rd_act) pe_filt <= glb_rd_data;
            if (rd_v && rd_act)  pe_act  <= glb_rd_data;
        end
    end

    always_comb begin
        state_nx    = state;
        cnt_nx      = cnt;
        out_cnt_nx  = out_cnt;
        busy        = 1'b1;
        done        = 1'b0;
        glb_rd_en   = 1'b0;
        glb_rd_addr = '0;
        pe_start    = 1'b0;
        ps_wr_en    = 1'b0;
        ps_wr_addr  = '0;
        ps_wr_data  = '0;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (go) begin
                    state_nx = LW_FETCH;
                    cnt_nx   = '0;
                end
            end
            LW_FETCH: begin
                glb_rd_en   = 1'b1;
                glb_rd_addr = ADDR_BITWIDTH'(W_BASE) + ADDR_BITWIDTH'(cnt);
                if (cnt == CNT_W'(W_CNT - 1)) begin
                    cnt_nx   = '0;
                    state_nx = LW_WAIT;
                end else begin
                    cnt_nx = cnt + 1'b1;
                end
            end
            LW_WAIT: begin
                if (pe_load_done) state_nx = LA_FETCH;
            end
            LA_FETCH: begin
                glb_rd_en   = 1'b1;
                glb_rd_addr = ADDR_BITWIDTH'(A_BASE) + ADDR_BITWIDTH'(cnt);
                if (cnt == CNT_W'(A_CNT - 1)) begin
                    cnt_nx   = '0;
                    state_nx = LA_WAIT;
                end else begin
                    cnt_nx = cnt + 1'b1;
                end
            end
            LA_WAIT: begin
                if (pe_load_done) begin
                    out_cnt_nx = '0;
                    state_nx   = START;
                end
            end
            START: begin
                pe_start = 1'b1;
                state_nx = WAIT_CD;
            end
            WAIT_CD: begin
                // Only a fresh 0->1 transition counts; a level left high from the previous compute is ignored.
                if (pe_compute_done && !cd_prev) state_nx = CAPTURE;
            end
            CAPTURE: begin
                ps_wr_en   = 1'b1;
                ps_wr_addr = ADDR_BITWIDTH'(PSUM_BASE) + ADDR_BITWIDTH'(out_cnt);
                ps_wr_data = psum_val;
                out_cnt_nx = out_cnt + 1'b1;
                state_nx   = (out_cnt == OCNT_W'(NUM_OUT - 1)) ? DONE : GAP;
            end
            GAP: begin
                state_nx = START;
            end
            DONE: begin
                busy     = 1'b0;
                done     = 1'b1;
                state_nx = IDLE;
            end
            default: begin
                busy     = 1'b0;
                state_nx = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_pe_load_sequencer.sv
// Self-checking bench for pe_load_sequencer: GLB memory model, inline PE responder, directed and randomized jobs.
module tb_pe_load_sequencer;

    localparam int DW = 16;
    localparam int AW = 10;
    localparam int KS = 3;
    localparam int AS = 5;
    localparam int WB = 0;
    localparam int AB = 64;
    localparam int PB = 0;
    localparam int NW = KS * KS;
    localparam int NA = AS * AS;
    localparam int NO = AS - KS + 1;

    logic          clk = 1'b0;
    logic          reset;
    logic          go;
    logic          busy, done;
    logic          glb_rd_en;
    logic [AW-1:0] glb_rd_addr;
    logic [DW-1:0] glb_rd_data;
    logic          pe_load_en_wght, pe_load_en_act;
    logic [DW-1:0] pe_filt, pe_act;
    logic          pe_load_done;
    logic          pe_start;
    logic          pe_compute_done;
    logic [DW-1:0] pe_out;
    logic          ps_wr_en;
    logic [AW-1:0] ps_wr_addr;
    logic [DW-1:0] ps_wr_data;

    always #5 clk = ~clk;

    pe_load_sequencer #(
        .DATA_BITWIDTH(DW),
        .ADDR_BITWIDTH(AW),
        .KERNEL_SIZE  (KS),
        .ACT_SIZE     (AS),
        .W_BASE       (WB),
        .A_BASE       (AB),
        .PSUM_BASE    (PB)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .go              (go),
        .busy            (busy),
        .done            (done),
        .glb_rd_en       (glb_rd_en),
        .glb_rd_addr     (glb_rd_addr),
        .glb_rd_data     (glb_rd_data),
        .pe_load_en_wght (pe_load_en_wght),
        .pe_load_en_act  (pe_load_en_act),
        .pe_filt         (pe_filt),
        .pe_act          (pe_act),
        .pe_load_done    (pe_load_done),
        .pe_start        (pe_start),
        .pe_compute_done (pe_compute_done),
        .pe_out          (pe_out),
        .ps_wr_en        (ps_wr_en),
        .ps_wr_addr      (ps_wr_addr),
        .ps_wr_data      (ps_wr_data)
    );

    logic [DW-1:0] mem [0:(1<<AW)-1];
    always @(posedge clk) if (glb_rd_en) glb_rd_data <= mem[glb_rd_addr];

    int checks = 0;
    int failures = 0;
    logic [DW-1:0] psv [0:NO-1];

    logic          s_busy, s_done, s_rd_en, s_en_w, s_en_a, s_start, s_wr_en;
    logic [AW-1:0] s_rd_addr, s_wr_addr;
    logic [DW-1:0] s_filt, s_act, s_wr_data;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] relu(input logic [DW-1:0] v);
`ifdef PSUM_RELU_EN
        return v[DW-1] ? '0 : v;
`else
        return v;
`endif
    endfunction

    // Sample outputs mid-cycle, then step to just after the next rising edge.
    task automatic cyc();
        @(negedge clk);
        s_busy = busy;       s_done = done;
        s_rd_en = glb_rd_en; s_rd_addr = glb_rd_addr;
        s_en_w = pe_load_en_wght; s_en_a = pe_load_en_act;
        s_filt = pe_filt;    s_act = pe_act;
        s_start = pe_start;  s_wr_en = ps_wr_en;
        s_wr_addr = ps_wr_addr; s_wr_data = ps_wr_data;
        @(posedge clk);
        #1;
    endtask

    task automatic run_job(input int dw, input int da, input bit stale);
        go = 1'b1;
        cyc();
        chk("busy_at_go", 32'(s_busy), 32'd0);
        go = 1'b0;
        cyc();
        chk("busy_next", 32'(s_busy), 32'd1);
        chk("rd_w0", 32'({s_rd_en, s_rd_addr}), 32'({1'b1, AW'(WB)}));
        cyc();
        for (int k = 0; k < NW; k++) begin
            cyc();
            chk("filt", 32'(s_filt), 32'(mem[WB + k]));
            chk("en_wght", 32'(s_en_w), 32'(k == 0));
        end
        repeat (dw) begin
            cyc();
            chk("no_early_act", 32'(s_rd_en), 32'd0);
        end
        pe_load_done = 1'b1;
        cyc();
        pe_load_done = 1'b0;
        chk("no_act_at_ld", 32'(s_rd_en), 32'd0);
        cyc();
        chk("rd_a0", 32'({s_rd_en, s_rd_addr}), 32'({1'b1, AW'(AB)}));
        cyc();
        for (int k = 0; k < NA; k++) begin
            cyc();
            chk("act", 32'(s_act), 32'(mem[AB + k]));
            chk("en_act", 32'(s_en_a), 32'(k == 0));
        end
        repeat (da) cyc();
        pe_load_done = 1'b1;
        if (stale) begin
            pe_compute_done = 1'b1;
            pe_out = 16'hDEAD;
        end
        cyc();
        pe_load_done = 1'b0;
        for (int i = 0; i < NO; i++) begin
            cyc();
            chk("start", 32'({s_start, s_wr_en}), 32'b10);
            if (stale && i == 0) begin
                repeat (3) begin
                    cyc();
                    chk("stale_no_wr", 32'({s_wr_en, s_start}), 32'd0);
                end
                pe_compute_done = 1'b0;
                cyc();
                chk("stale_low", 32'(s_wr_en), 32'd0);
            end else begin
                repeat ($urandom_range(0, 3)) begin
                    cyc();
                    chk("wait_cd", 32'({s_wr_en, s_start}), 32'd0);
                end
            end
            pe_compute_done = 1'b1;
            pe_out = psv[i];
            cyc();
            chk("edge_no_wr", 32'(s_wr_en), 32'd0);
            cyc();
            chk("wr_en", 32'(s_wr_en), 32'd1);
            chk("wr_addr", 32'(s_wr_addr), 32'(PB + i));
            chk("wr_data", 32'(s_wr_data), 32'(relu(psv[i])));
            chk("busy_cap", 32'({s_done, s_busy}), 32'b01);
            pe_compute_done = 1'b0;
            pe_out = DW'($urandom);
            cyc();
            if (i < NO - 1) chk("gap", 32'({s_start, s_wr_en, s_done}), 32'd0);
            else            chk("done", 32'({s_done, s_busy}), 32'b10);
        end
        cyc();
        chk("idle_after", 32'({s_done, s_busy, s_start}), 32'd0);
    endtask

    task automatic randomize_job();
        for (int k = 0; k < NW; k++) mem[WB + k] = DW'($urandom);
        for (int k = 0; k < NA; k++) mem[AB + k] = DW'($urandom);
        for (int i = 0; i < NO; i++) psv[i] = DW'($urandom);
    endtask

    initial begin
        reset = 1'b0;
        go = 1'b1;
        pe_load_done = 1'b0;
        pe_compute_done = 1'b0;
        pe_out = '0;
        repeat (3) cyc();
        chk("rst_ctrl", 32'({s_busy, s_done, s_rd_en, s_en_w, s_en_a, s_start, s_wr_en}), 32'd0);
        chk("rst_addr", 32'({s_rd_addr, s_wr_addr}), 32'd0);
        chk("rst_streams", {s_filt, s_act}, 32'd0);
        chk("rst_wr_data", 32'(s_wr_data), 32'd0);
        reset = 1'b1;
        go = 1'b0;
        cyc();

        for (int k = 0; k < NW; k++) mem[WB + k] = DW'(k + 1);
        for (int k = 0; k < NA; k++) mem[AB + k] = DW'(100 + k);
        psv[0] = 16'd7;
        psv[1] = 16'hFFFB;
        psv[2] = 16'd20;
        run_job(2, 2, 1'b0);

        randomize_job();
        run_job($urandom_range(0, 4), $urandom_range(0, 4), 1'b1);
        randomize_job();
        run_job($urandom_range(0, 4), $urandom_range(0, 4), 1'b0);

        // Abandon a job partway through the activation fetch.
        randomize_job();
        go = 1'b1;
        cyc();
        go = 1'b0;
        repeat (2 + NW) cyc();
        pe_load_done = 1'b1;
        cyc();
        pe_load_done = 1'b0;
        repeat (5) cyc();
        reset = 1'b0;
        #1;
        chk("midrst_ctrl", 32'({busy, done, glb_rd_en, pe_load_en_wght, pe_load_en_act, pe_start, ps_wr_en}), 32'd0);
        chk("midrst_addr", 32'(glb_rd_addr), 32'd0);
        chk("midrst_streams", {pe_filt, pe_act}, 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        cyc();
        chk("midrst_idle", 32'({s_busy, s_done}), 32'd0);

        randomize_job();
        run_job($urandom_range(0, 4), $urandom_range(0, 4), 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
